// File: rtl/reg_writeback_queue.sv
`default_nettype none
// ============================================================================
// Module   : reg_writeback_queue
// Purpose  : In-order write-back FIFO in front of register_bank's single write
//            port, with two combinational forwarding lookups for operand fetch.
// Revision : 1.0
// ============================================================================
module reg_writeback_queue #(
  parameter int ADDRESS_SIZE  = 5,
  parameter int REGISTER_SIZE = 8,
  parameter int DEPTH         = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [ADDRESS_SIZE-1:0]      req_addr,
  input  logic [REGISTER_SIZE-1:0]     req_data,
  input  logic                         drain_en,
  output logic                         write,
  output logic [ADDRESS_SIZE-1:0]      addr_in,
  output logic [REGISTER_SIZE-1:0]     data_in,
  input  logic [ADDRESS_SIZE-1:0]      lookup_addr1,
  output logic                         fwd_hit1,
  output logic [REGISTER_SIZE-1:0]     fwd_data1,
  input  logic [ADDRESS_SIZE-1:0]      lookup_addr2,
  output logic                         fwd_hit2,
  output logic [REGISTER_SIZE-1:0]     fwd_data2,
  output logic [$clog2(DEPTH):0]       count,
  output logic                         empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);

  logic [ADDRESS_SIZE-1:0]  entry_addr_q [DEPTH];
  logic [ADDRESS_SIZE-1:0]  entry_addr_d [DEPTH];
  logic [REGISTER_SIZE-1:0] entry_data_q [DEPTH];
  logic [REGISTER_SIZE-1:0] entry_data_d [DEPTH];
  logic [PTR_W-1:0]         head_q, head_d;
  logic [PTR_W-1:0]         tail_q, tail_d;
  logic [CNT_W-1:0]         count_q, count_d;

  logic w_store;
  logic w_pop;

  // Slot k is the k-th oldest entry; live slots are those below count.
  logic [PTR_W-1:0] w_slot_idx  [DEPTH];
  logic             w_slot_live [DEPTH];

  for (genvar k = 0; k < DEPTH; k++) begin : g_slot
    assign w_slot_idx[k]  = head_q + PTR_W'(k);
    assign w_slot_live[k] = (CNT_W'(k) < count_q);
  end

  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign req_ready = (count_q < C_DEPTH);

  // Address-0 requests complete the handshake but are dropped.
  assign w_store = req_valid && req_ready && (req_addr != '0);
  assign w_pop   = drain_en && !empty && !reset;

  assign write   = w_pop;
  assign addr_in = empty ? '0 : entry_addr_q[head_q];
  assign data_in = empty ? '0 : entry_data_q[head_q];

  // Scanning oldest to youngest lets the youngest match win.
  always_comb begin
    fwd_hit1  = 1'b0;
    fwd_data1 = '0;
    fwd_hit2  = 1'b0;
    fwd_data2 = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (w_slot_live[k] && (lookup_addr1 != '0) &&
          (entry_addr_q[w_slot_idx[k]] == lookup_addr1)) begin
        fwd_hit1  = 1'b1;
        fwd_data1 = entry_data_q[w_slot_idx[k]];
      end
      if (w_slot_live[k] && (lookup_addr2 != '0) &&
          (entry_addr_q[w_slot_idx[k]] == lookup_addr2)) begin
        fwd_hit2  = 1'b1;
        fwd_data2 = entry_data_q[w_slot_idx[k]];
      end
    end
  end

  always_comb begin
    entry_addr_d = entry_addr_q;
    entry_data_d = entry_data_q;
    head_d       = head_q;
    tail_d       = tail_q;
    count_d      = count_q;
    if (w_store) begin
      entry_addr_d[tail_q] = req_addr;
      entry_data_d[tail_q] = req_data;
      tail_d               = tail_q + 1'b1;
    end
    if (w_pop) begin
      head_d = head_q + 1'b1;
    end
    case ({w_store, w_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage needs no reset: validity comes from head/count alone.
  always_ff @(posedge clk) begin
    entry_addr_q <= entry_addr_d;
    entry_data_q <= entry_data_d;
  end

endmodule
`default_nettype wire

// File: doc/reg_writeback_queue.md
Name: reg_writeback_queue

Overview:
- Write-side client of register_bank: buffers register write-back requests from the execute stage in an in-order FIFO.
- Drains at most one request per cycle onto the bank's single write port (write, addr_in, data_in).
- Provides two forwarding lookups so operand fetch sees queued values that the bank does not yet hold.
- Sits between the write-back stage and register_bank; its bank-side outputs connect directly to the bank's inputs of the same names.

Parameters:
ADDRESS_SIZE, 5, register address width; must match register_bank.
REGISTER_SIZE, 8, register data width; must match register_bank.
DEPTH, 4, FIFO entries; power of two, >= 2.

Ports:
clk  input  1  clock; all state updates on rising edge.
reset  input  1  synchronous, active-high; clears queue.
req_valid  input  1  write-back request present.
req_ready  output  1  queue can accept a request this cycle.
req_addr  input  ADDRESS_SIZE  destination register.
req_data  input  REGISTER_SIZE  value to write.
drain_en  input  1  permits a bank write this cycle (0 = bank port busy/stalled).
write  output  1  bank write enable.
addr_in  output  ADDRESS_SIZE  bank write address.
data_in  output  REGISTER_SIZE  bank write data.
lookup_addr1  input  ADDRESS_SIZE  operand 1 address (same value driven to bank addr_out1).
fwd_hit1  output  1  pending write to lookup_addr1 exists.
fwd_data1  output  REGISTER_SIZE  youngest pending value for lookup_addr1.
lookup_addr2  input  ADDRESS_SIZE  operand 2 address.
fwd_hit2  output  1  as fwd_hit1, for lookup_addr2.
fwd_data2  output  REGISTER_SIZE  as fwd_data1, for lookup_addr2.
count  output  log2(DEPTH)+1  number of valid entries.
empty  output  1  count == 0.

Behaviour:
- State: DEPTH entries {addr, data}; head and tail pointers (log2(DEPTH) bits, natural wrap); count register.
- Reset (reset=1 at edge): head = tail = count = 0; all entries invalid; entry contents are don't-care.
- Post-reset outputs: write=0, req_ready=1, empty=1, fwd_hit1/2=0, count=0.
- While reset is high, write is forced to 0 combinationally; pending entries are discarded and never written.
- req_ready = (count < DEPTH), registered-state only; it does not depend on same-cycle drain, so a full queue never accepts a request.
- Enqueue fires when req_valid && req_ready at the edge: entry[tail] = {req_addr, req_data}; tail += 1.
- Address-0 requests are accepted (handshake completes) but not stored; tail and count are unchanged.
- Dequeue: write = drain_en && !empty && !reset; addr_in/data_in = entry[head] when !empty, else 0.
  - The bank captures the write at the edge; the queue pops at the same edge (head += 1).
- count next-state: +1 on store only; -1 on pop only; unchanged on store+pop or neither.
- Latency: request accepted at edge N appears on the write port in cycle N+1 (empty queue, drain_en=1) and is written into the bank at edge N+1.
- Ordering: strict FIFO. Duplicate addresses are all kept and written in order, so the last write wins in the bank.
- Forwarding (combinational):
  - Compare lookup_addrN against every valid entry, including the head entry being written this cycle.
  - fwd_hitN = any match.
  - fwd_dataN = data of the youngest (closest to tail) matching entry; 0 when no hit.
  - lookup_addrN == 0 never hits.
- Boundaries:
  - Full + drain: pop happens, no store; req_ready rises next cycle.
  - Empty + request: store happens, no write this cycle.
  - Pointer wrap at DEPTH is transparent.
  - drain_en=0 holds the queue and keeps forwarding active.

Test Plan:
- Reset, then 1 request (addr=3, data=0x55), drain_en=1 -> cycle+1: write=1, addr_in=3, data_in=0x55; next cycle: empty=1, write=0.
- drain_en=0, push addr 1..4 with data 0x10..0x13 -> count=4, req_ready=0, 5th request (addr 5) not accepted; set drain_en=1 -> bank writes 1,2,3,4 in order on 4 consecutive cycles.
- drain_en=0, push (7,0xA1), then (7,0xB2); lookup_addr1=7, lookup_addr2=8 -> fwd_hit1=1, fwd_data1=0xB2, fwd_hit2=0, fwd_data2=0.
- Request (0,0xFF) -> req_ready=1, count stays 0, write never asserted; lookup_addr1=0 -> fwd_hit1=0.
- Full queue, drain_en=1 and req_valid=1 same cycle -> count 4->3, request not stored; then run 10 push/pop pairs across pointer wrap -> all data emerges in order, count stable.
- 3 entries queued, assert reset for 1 cycle -> write=0 during reset, count=0, empty=1 after, no queued value ever reaches the bank.
